// File: rtl/sccb_responder_pkg.sv
// Shared types and constants for the SCCB responder: FSM state encoding, default device
// address and line idle level.
package sccb_responder_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StId,
      StIdAck,
      StSub,
      StSubAck,
      StWr,
      StWrAck,
      StRd,
      StIgnore
   } state_t;

   localparam logic [6:0] DefaultDevId = 7'h21;
   localparam logic       SdaIdle      = 1'b1;
   localparam logic       SclIdle      = 1'b1;
   localparam logic [3:0] LastBit      = 4'd7;
   localparam logic [3:0] AckSlot      = 4'd8;

   function automatic logic id_match(input logic [7:0] id_byte, input logic [6:0] dev_id);
      return id_byte[7:1] == dev_id;
   endfunction

endpackage

// File: rtl/sccb_responder_line_filter.sv
// Synchronizer plus glitch filter for one SCCB line; emits the accepted level and
// single-cycle rise/fall pulses aligned with the level change.
module sccb_responder_line_filter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 3,
   parameter logic        IDLE_LEVEL  = 1'b1
) (
   input  logic clk,
   input  logic reset_b,
   input  logic pad_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [FILTER_LEN-2:0]  hist_q, hist_d;
   logic [FILTER_LEN-1:0]  window;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   // The synchronizer output is the newest window sample, so total lag is
   // SYNC_STAGES + FILTER_LEN cycles.
   assign window = {hist_q, sync_q[SYNC_STAGES-1]};

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], pad_i};
      hist_d  = window[FILTER_LEN-2:0];
      level_d = level_q;
      if (&window) begin
         level_d = 1'b1;
      end else if (~|window) begin
         level_d = 1'b0;
      end
      rise_d = level_d & ~level_q;
      fall_d = ~level_d & level_q;
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         sync_q  <= {SYNC_STAGES{IDLE_LEVEL}};
         hist_q  <= {(FILTER_LEN - 1){IDLE_LEVEL}};
         level_q <= IDLE_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         hist_q  <= hist_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/sccb_responder.sv
// Camera-side SCCB responder: decodes START/STOP, device ID, sub-address and data bytes
// from filtered lines and drives open-drain ACK/read data toward the register bank.
module sccb_responder
   import sccb_responder_pkg::*;
#(
   parameter logic [6:0]  DEV_ID      = DefaultDevId,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 3
) (
   input  logic       clk,
   input  logic       reset_b,
   input  logic       sio_c,
   input  logic       sio_d_in,
   output logic       sio_d_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   logic scl, scl_rise, scl_fall;
   logic sda, sda_rise, sda_fall;

   sccb_responder_line_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN),
      .IDLE_LEVEL (SclIdle)
   ) u_scl_filter (
      .clk    (clk),
      .reset_b(reset_b),
      .pad_i  (sio_c),
      .level_o(scl),
      .rise_o (scl_rise),
      .fall_o (scl_fall)
   );

   sccb_responder_line_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN),
      .IDLE_LEVEL (SdaIdle)
   ) u_sda_filter (
      .clk    (clk),
      .reset_b(reset_b),
      .pad_i  (sio_d_in),
      .level_o(sda),
      .rise_o (sda_rise),
      .fall_o (sda_fall)
   );

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       we_q, we_d;
   logic       oe_q, oe_d;
   logic       busy_q, busy_d;
   logic [7:0] bit_in;
   logic       start_cond, stop_cond;

   assign bit_in     = {shift_q[6:0], sda};
   assign start_cond = sda_fall & scl;
   assign stop_cond  = sda_rise & scl;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      oe_d    = oe_q;
      busy_d  = busy_q;
      reg_re  = 1'b0;
      if (start_cond) begin
         state_d = StId;
         cnt_d   = 4'd0;
         oe_d    = 1'b0;
         busy_d  = 1'b1;
      end else if (stop_cond) begin
         state_d = StIdle;
         cnt_d   = 4'd0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: ;
            StId, StSub, StWr: begin
               if (scl_rise) begin
                  shift_d = bit_in;
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == LastBit) begin
                     if (state_q == StId) begin
                        state_d = id_match(bit_in, DEV_ID) ? StIdAck : StIgnore;
                     end else if (state_q == StSub) begin
                        addr_d  = bit_in;
                        state_d = StSubAck;
                     end else begin
                        wdata_d = bit_in;
                        we_d    = 1'b1;
                        state_d = StWrAck;
                     end
                  end
               end
            end
            // First scl fall (end of bit 8) asserts ACK; the next one (end of the 9th clock)
            // releases it and moves on.
            StIdAck, StSubAck, StWrAck: begin
               if (scl_fall) begin
                  if (!oe_q) begin
                     oe_d = 1'b1;
                  end else begin
                     oe_d  = 1'b0;
                     cnt_d = 4'd0;
                     if (state_q == StWrAck) begin
                        addr_d  = addr_q + 8'd1;
                        state_d = StWr;
                     end else if (state_q == StSubAck) begin
                        state_d = StWr;
                     end else if (!shift_q[0]) begin
                        state_d = StSub;
                     end else begin
                        reg_re  = 1'b1;
                        shift_d = reg_rdata;
                        oe_d    = ~reg_rdata[7];
                        state_d = StRd;
                     end
                  end
               end
            end
            // cnt==0 on a fall only happens right after a master ACK: reload the next byte.
            StRd: begin
               if (scl_rise) begin
                  if (cnt_q == AckSlot) begin
                     if (!sda) begin
                        addr_d = addr_q + 8'd1;
                        cnt_d  = 4'd0;
                     end else begin
                        state_d = StIgnore;
                     end
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end else if (scl_fall) begin
                  if (cnt_q == 4'd0) begin
                     reg_re  = 1'b1;
                     shift_d = reg_rdata;
                     oe_d    = ~reg_rdata[7];
                  end else if (cnt_q == AckSlot) begin
                     oe_d = 1'b0;
                  end else begin
                     shift_d = {shift_q[6:0], 1'b0};
                     oe_d    = ~shift_q[6];
                  end
               end
            end
            StIgnore: oe_d = 1'b0;
            default: begin
               state_d = StIdle;
               oe_d    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         shift_q <= 8'h00;
         addr_q  <= 8'h00;
         wdata_q <= 8'h00;
         we_q    <= 1'b0;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
      end
   end

   assign sio_d_oe  = oe_q;
   assign reg_addr  = addr_q;
   assign reg_wdata = wdata_q;
   assign reg_we    = we_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: table of write transactions plus hand-built read, abort,
// reset and glitch sequences against a wired-AND bus and a small register bank.
module tb_sccb_responder;

   localparam int Q = 8;
   localparam int H = 16;

   logic       clk = 1'b0;
   logic       reset_b = 1'b0;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       sio_d_in;
   logic       sio_d_oe;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic       reg_we, reg_re, busy;
   logic [7:0] mem [256];

   always #5 clk = ~clk;

   assign sio_d_in  = m_sda & ~sio_d_oe;
   assign reg_rdata = mem[reg_addr];

   sccb_responder dut (
      .clk      (clk),
      .reset_b  (reset_b),
      .sio_c    (m_scl),
      .sio_d_in (sio_d_in),
      .sio_d_oe (sio_d_oe),
      .reg_addr (reg_addr),
      .reg_wdata(reg_wdata),
      .reg_we   (reg_we),
      .reg_re   (reg_re),
      .reg_rdata(reg_rdata),
      .busy     (busy)
   );

   int         we_cnt = 0, re_cnt = 0, oe_cnt = 0, both_cnt = 0;
   logic [7:0] we_addr_q[$], we_data_q[$], re_addr_q[$];

   always @(negedge clk) begin
      if (reg_we) begin
         we_cnt++;
         we_addr_q.push_back(reg_addr);
         we_data_q.push_back(reg_wdata);
      end
      if (reg_re) begin
         re_cnt++;
         re_addr_q.push_back(reg_addr);
      end
      if (sio_d_oe) oe_cnt++;
      if (reg_we && reg_re) both_cnt++;
   end

   int n_vec = 0, n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      wait_clk(Q); m_sda = 1'b1;
      wait_clk(Q); m_scl = 1'b1;
      wait_clk(H); m_sda = 1'b0;
      wait_clk(H); m_scl = 1'b0;
   endtask

   task automatic bus_stop();
      wait_clk(Q); m_sda = 1'b0;
      wait_clk(Q); m_scl = 1'b1;
      wait_clk(H); m_sda = 1'b1;
      wait_clk(H);
   endtask

   task automatic send_bit(input logic b, output logic line, output logic oe);
      wait_clk(Q); m_sda = b;
      wait_clk(Q); m_scl = 1'b1;
      wait_clk(H / 2);
      line = sio_d_in;
      oe   = sio_d_oe;
      wait_clk(H / 2); m_scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, output logic acked);
      logic l, o;
      for (int i = 7; i >= 0; i--) send_bit(d[i], l, o);
      send_bit(1'b1, l, o);
      acked = o;
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d, output logic oe9);
      logic l, o;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, l, o);
         d[i] = l;
      end
      send_bit(mack, l, o);
      oe9 = o;
   endtask

   typedef struct {
      logic [7:0]      id;
      int              n;
      logic [3:0][7:0] b;
      logic [4:0]      ack;
      int              we;
      logic [7:0]      fa, fd, la, ld, final_addr;
   } wvec_t;

   function automatic wvec_t mk(input logic [7:0] id, input int n, input logic [7:0] b0,
                                input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                                input logic [4:0] ack, input int we, input logic [7:0] fa,
                                input logic [7:0] fd, input logic [7:0] la, input logic [7:0] ld,
                                input logic [7:0] final_addr);
      wvec_t v;
      v.id = id; v.n = n; v.b = {b3, b2, b1, b0}; v.ack = ack; v.we = we;
      v.fa = fa; v.fd = fd; v.la = la; v.ld = ld; v.final_addr = final_addr;
      return v;
   endfunction

   wvec_t vec [6];

   initial begin
      logic [4:0] ack_mask;
      logic       a, l, o, oe9;
      logic [7:0] d;
      int         we0, re0, oe0;

      for (int k = 0; k < 256; k++) mem[k] = 8'(k) ^ 8'h5A;
      mem[8'h0A] = 8'h76;
      mem[8'h05] = 8'hC3;
      mem[8'h06] = 8'h3C;
      mem[8'h07] = 8'h81;

      vec[0] = mk(8'h42, 2, 8'h12, 8'h80, 8'h00, 8'h00, 5'b00111, 1, 8'h12, 8'h80, 8'h12, 8'h80, 8'h13);
      vec[1] = mk(8'h60, 2, 8'h12, 8'h80, 8'h00, 8'h00, 5'b00000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h13);
      vec[2] = mk(8'h42, 4, 8'hFF, 8'h11, 8'h22, 8'h33, 5'b11111, 3, 8'hFF, 8'h11, 8'h01, 8'h33, 8'h02);
      vec[3] = mk(8'h42, 1, 8'h0A, 8'h00, 8'h00, 8'h00, 5'b00011, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A);
      vec[4] = mk(8'h40, 2, 8'h0A, 8'h99, 8'h00, 8'h00, 5'b00000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A);
      vec[5] = mk(8'h42, 3, 8'h30, 8'hA5, 8'h5A, 8'h00, 5'b01111, 2, 8'h30, 8'hA5, 8'h31, 8'h5A, 8'h32);

      wait_clk(4);
      reset_b = 1'b1;
      wait_clk(4);
      check("reset_oe", 32'(sio_d_oe), 0);
      check("reset_addr", 32'(reg_addr), 0);
      check("reset_wdata", 32'(reg_wdata), 0);
      check("reset_we", 32'(reg_we), 0);
      check("reset_re", 32'(reg_re), 0);
      check("reset_busy", 32'(busy), 0);

      for (int v = 0; v < 6; v++) begin
         we0 = we_cnt; re0 = re_cnt; oe0 = oe_cnt;
         bus_start();
         check($sformatf("v%0d_busy_start", v), 32'(busy), 1);
         ack_mask = '0;
         send_byte(vec[v].id, a);
         ack_mask[0] = a;
         for (int k = 0; k < vec[v].n; k++) begin
            send_byte(vec[v].b[k], a);
            ack_mask[k+1] = a;
         end
         check($sformatf("v%0d_busy_pre_stop", v), 32'(busy), 1);
         bus_stop();
         check($sformatf("v%0d_acks", v), 32'(ack_mask), 32'(vec[v].ack));
         check($sformatf("v%0d_we_count", v), 32'(we_cnt - we0), 32'(vec[v].we));
         check($sformatf("v%0d_re_count", v), 32'(re_cnt - re0), 0);
         check($sformatf("v%0d_busy_end", v), 32'(busy), 0);
         check($sformatf("v%0d_final_addr", v), 32'(reg_addr), 32'(vec[v].final_addr));
         if (vec[v].we > 0) begin
            check($sformatf("v%0d_first_addr", v), 32'(we_addr_q[we0]), 32'(vec[v].fa));
            check($sformatf("v%0d_first_data", v), 32'(we_data_q[we0]), 32'(vec[v].fd));
            check($sformatf("v%0d_last_addr", v), 32'(we_addr_q[we0+vec[v].we-1]), 32'(vec[v].la));
            check($sformatf("v%0d_last_data", v), 32'(we_data_q[we0+vec[v].we-1]), 32'(vec[v].ld));
         end
         if (vec[v].ack == 5'b0) check($sformatf("v%0d_oe_quiet", v), 32'(oe_cnt - oe0), 0);
      end

      // Sub-address write, repeated START, single read with master NACK.
      we0 = we_cnt; re0 = re_cnt;
      bus_start();
      send_byte(8'h42, a); check("rd1_ack_id", 32'(a), 1);
      send_byte(8'h0A, a); check("rd1_ack_sub", 32'(a), 1);
      bus_start();
      send_byte(8'h43, a); check("rd1_ack_rid", 32'(a), 1);
      read_byte(1'b1, d, oe9);
      check("rd1_data", 32'(d), 32'h76);
      check("rd1_ack_slot_released", 32'(oe9), 0);
      bus_stop();
      check("rd1_re_count", 32'(re_cnt - re0), 1);
      check("rd1_re_addr", 32'(re_addr_q[re0]), 32'h0A);
      check("rd1_we_count", 32'(we_cnt - we0), 0);
      check("rd1_busy_end", 32'(busy), 0);

      // Burst read ACK, ACK, NACK then an ignored byte.
      re0 = re_cnt;
      bus_start();
      send_byte(8'h42, a);
      send_byte(8'h05, a);
      bus_start();
      send_byte(8'h43, a);
      read_byte(1'b0, d, oe9); check("rd3_data0", 32'(d), 32'hC3);
      read_byte(1'b0, d, oe9); check("rd3_data1", 32'(d), 32'h3C);
      read_byte(1'b1, d, oe9); check("rd3_data2", 32'(d), 32'h81);
      oe0 = oe_cnt;
      send_byte(8'hFF, a);
      check("rd3_ignore_ack", 32'(a), 0);
      check("rd3_ignore_oe", 32'(oe_cnt - oe0), 0);
      check("rd3_busy_ignore", 32'(busy), 1);
      bus_stop();
      check("rd3_re_count", 32'(re_cnt - re0), 3);
      check("rd3_re_addr0", 32'(re_addr_q[re0]), 32'h05);
      check("rd3_re_addr1", 32'(re_addr_q[re0+1]), 32'h06);
      check("rd3_re_addr2", 32'(re_addr_q[re0+2]), 32'h07);
      check("rd3_final_addr", 32'(reg_addr), 32'h07);
      check("rd3_busy_end", 32'(busy), 0);

      // One-cycle scl glitch before the sub-address must not be counted as a bit.
      we0 = we_cnt;
      bus_start();
      send_byte(8'h42, a);
      wait_clk(Q); m_sda = 1'b0;
      wait_clk(2); m_scl = 1'b1;
      wait_clk(1); m_scl = 1'b0;
      wait_clk(Q);
      send_byte(8'h34, a);
      send_byte(8'h56, a);
      bus_stop();
      check("glitch_we_count", 32'(we_cnt - we0), 1);
      check("glitch_addr", 32'(we_addr_q[we0]), 32'h34);
      check("glitch_data", 32'(we_data_q[we0]), 32'h56);

      // STOP after a partial data byte discards it.
      we0 = we_cnt;
      bus_start();
      send_byte(8'h42, a);
      send_byte(8'h50, a);
      for (int i = 0; i < 4; i++) send_bit(1'(i & 1), l, o);
      bus_stop();
      check("abort_we_count", 32'(we_cnt - we0), 0);
      check("abort_busy", 32'(busy), 0);

      // Reset asserted while ACK is being driven.
      bus_start();
      for (int i = 7; i >= 0; i--) send_bit(1'(8'h42 >> i), l, o);
      wait_clk(Q); m_sda = 1'b1;
      wait_clk(Q); m_scl = 1'b1;
      wait_clk(H / 2);
      check("rst_pre_oe", 32'(sio_d_oe), 1);
      reset_b = 1'b0;
      #1;
      check("rst_oe", 32'(sio_d_oe), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_addr", 32'(reg_addr), 0);
      wait_clk(4);
      reset_b = 1'b1;
      wait_clk(20);
      check("rst_idle_busy", 32'(busy), 0);

      check("we_re_exclusive", 32'(both_cnt), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
